// File: rtl/vga_pkg.sv
// Shared timing constants, pipeline record and address helper for the VGA pixel streamer.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  localparam int BYTES_PER_LINE = H_VISIBLE / 8;  // 80
  localparam int PIPE_LAT       = 3;

  // Per-pixel attributes carried alongside the memory access latency.
  typedef struct packed {
    logic       vis;
    logic       hs;
    logic       vs;
    logic [2:0] hlo;
  } pipe_t;

  // Syncs idle high while the pipeline is empty.
  localparam pipe_t PIPE_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, hlo: 3'd0};

  // Start address of a line: v*80 as two shifts, fits 16 bits for every legal v.
  function automatic logic [15:0] line_base(input logic [9:0] v);
    logic [15:0] vw;
    vw = {6'd0, v};
    return (vw << 6) + (vw << 4);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with stage-0 visible/sync decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int VIS_LINES    = V_VISIBLE,
  parameter int FRONT_LINES  = V_FRONT,
  parameter int SYNC_LINES   = V_SYNC,
  parameter int BACK_LINES   = V_BACK
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       vis,
  output logic       hs,
  output logic       vs
);

  localparam int V_TOT = VIS_LINES + FRONT_LINES + SYNC_LINES + BACK_LINES;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(VIS_LINES);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(VIS_LINES + FRONT_LINES);
  localparam logic [9:0] VS_LAST    = 10'(VIS_LINES + FRONT_LINES + SYNC_LINES - 1);

  // Raster scan: h wraps every line, v advances on the h wrap and wraps per frame.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Decode straight off the counters; these form stage 0 of the output pipeline.
  always_comb begin
    vis = (h < H_VIS_END) && (v < V_VIS_END);
    hs  = !((h >= HS_FIRST) && (h <= HS_LAST));
    vs  = !((v >= VS_FIRST) && (v <= VS_LAST));
  end

endmodule

// File: rtl/vga_pixel_stream.sv
// 640x480 VGA pixel streamer: bitmap address generation, 3-cycle aligned
// pipeline, 1-bpp serializer and a free-running blink strobe divider.
module vga_pixel_stream
  import vga_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter int BLINK_HZ    = 10,
  parameter int VIS_LINES   = V_VISIBLE,
  parameter int FRONT_LINES = V_FRONT,
  parameter int SYNC_LINES  = V_SYNC,
  parameter int BACK_LINES  = V_BACK
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [15:0] glyph_addr,
  input  logic [7:0]  glyph_data,
  output logic        display_area,
  output logic        serial_output,
  output logic        hsync,
  output logic        vsync,
  output logic        tenH_clk
);

  localparam int DIV = CLK_HZ / BLINK_HZ;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [9:0]  h;
  logic [9:0]  v;
  logic        vis;
  logic        hs;
  logic        vs;
  pipe_t       stage0;
  pipe_t       pipe [PIPE_LAT-1];
  logic [7:0]  shreg;
  logic [DW-1:0] div;

  vga_timing #(
    .VIS_LINES   (VIS_LINES),
    .FRONT_LINES (FRONT_LINES),
    .SYNC_LINES  (SYNC_LINES),
    .BACK_LINES  (BACK_LINES)
  ) u_timing (
    .vga_clk (vga_clk),
    .reset   (reset),
    .h       (h),
    .v       (v),
    .vis     (vis),
    .hs      (hs),
    .vs      (vs)
  );

  // Bundle the stage-0 decode with the pixel-within-byte index.
  always_comb begin
    stage0 = '{vis: vis, hs: hs, vs: vs, hlo: h[2:0]};
  end

  // Byte address for the visible pixel; held through blanking so the memory sees no churn.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      glyph_addr <= '0;
    end else if (vis) begin
      glyph_addr <= line_base(v) + {9'd0, h[9:3]};
    end
  end

  // Delay line matching address register plus memory read, so the last entry meets glyph_data.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT - 1; i++) pipe[i] <= PIPE_IDLE;
    end else begin
      pipe[0] <= stage0;
      for (int i = 1; i < PIPE_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Output stage: register syncs/visible flag and serialize the byte MSB first.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      display_area  <= 1'b0;
      serial_output <= 1'b0;
      hsync         <= 1'b1;
      vsync         <= 1'b1;
      shreg         <= '0;
    end else begin
      display_area <= pipe[PIPE_LAT-2].vis;
      hsync        <= pipe[PIPE_LAT-2].hs;
      vsync        <= pipe[PIPE_LAT-2].vs;
      if (pipe[PIPE_LAT-2].vis && (pipe[PIPE_LAT-2].hlo == 3'd0)) begin
        serial_output <= glyph_data[7];
        shreg         <= {glyph_data[6:0], 1'b0};
      end else if (pipe[PIPE_LAT-2].vis) begin
        serial_output <= shreg[7];
        shreg         <= {shreg[6:0], 1'b0};
      end else begin
        serial_output <= 1'b0;
      end
    end
  end

  // Blink strobe: free-running modulo-DIV counter, one-cycle pulse on its last count.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      div      <= '0;
      tenH_clk <= 1'b0;
    end else begin
      tenH_clk <= (div == DIV_LAST);
      div      <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Scoreboard bench for vga_pixel_stream: full-width lines, shortened frame height.
module tb_vga_pixel_stream;

  localparam int HT = 800;
  localparam int VV = 24;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VV + VF + VS + VB;

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] glyph_addr;
  logic [7:0]  glyph_data = 8'd0;
  logic        display_area;
  logic        serial_output;
  logic        hsync;
  logic        vsync;
  logic        tenH_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  int mem_mode = 0;
  int th = 0, tv = 0, ph = 0, pv = 0;
  int frame = 0, edge_n = 0;
  int exp_addr = 0;
  logic [3:0] sbq [$];

  bit stats_on = 1'b0;
  int hs_low = 0, da_high = 0, vs_low = 0;
  int hs_fall = -1, vs_fall = -1;
  logic [7:0] first_byte = 8'd0;

  always #5 vga_clk = ~vga_clk;

  vga_pixel_stream #(
    .CLK_HZ      (100),
    .BLINK_HZ    (10),
    .VIS_LINES   (VV),
    .FRONT_LINES (VF),
    .SYNC_LINES  (VS),
    .BACK_LINES  (VB)
  ) dut (
    .vga_clk       (vga_clk),
    .reset         (reset),
    .glyph_addr    (glyph_addr),
    .glyph_data    (glyph_data),
    .display_area  (display_area),
    .serial_output (serial_output),
    .hsync         (hsync),
    .vsync         (vsync),
    .tenH_clk      (tenH_clk)
  );

  function automatic logic [7:0] mem_byte(input int a);
    if (mem_mode == 0) return (a == 0) ? 8'hA5 : 8'h00;
    return 8'(a);
  endfunction

  // Synchronous-read bitmap memory.
  always @(posedge vga_clk) glyph_data <= mem_byte(int'(glyph_addr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    logic vis, hs, vs, pix;
    logic [7:0] b;
    logic [3:0] e;
    @(posedge vga_clk);
    vis = (th < 640) && (tv < VV);
    hs  = !((th >= 656) && (th < 752));
    vs  = !((tv >= VV + VF) && (tv < VV + VF + VS));
    b   = mem_byte(tv * 80 + th / 8);
    pix = vis ? b[7 - (th % 8)] : 1'b0;
    sbq.push_back({vis, pix, hs, vs});
    if (vis) exp_addr = tv * 80 + th / 8;
    ph = th;
    pv = tv;
    if (th == HT - 1) begin
      th = 0;
      if (tv == VT - 1) begin
        tv = 0;
        frame++;
      end else tv++;
    end else th++;
    edge_n++;
    @(negedge vga_clk);
    if (sbq.size() == 3) e = sbq.pop_front();
    else e = 4'b0011;
    check("pix", {display_area, serial_output, hsync, vsync}, e);
    check("tenh", tenH_clk, (edge_n % 10) == 0);
    check("addr", glyph_addr, exp_addr);
    if (pv == 1 && ph == 8) check("addr_v1h8", glyph_addr, 81);
    if (pv == VV - 1 && ph == 632) check("addr_last", glyph_addr, (VV - 1) * 80 + 79);
    if (pv == 0 && ph == 0) check("addr_first", glyph_addr, 0);
    if (stats_on) begin
      if (edge_n <= HT) begin
        if (!hsync) hs_low++;
        if (display_area) da_high++;
        if (!hsync && hs_fall < 0) hs_fall = edge_n;
      end
      if (edge_n <= HT * VT) begin
        if (!vsync) vs_low++;
        if (!vsync && vs_fall < 0) vs_fall = edge_n;
      end
      if (edge_n >= 3 && edge_n <= 10) first_byte = {first_byte[6:0], serial_output};
      if (edge_n == 11) check("after_byte", serial_output, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    check("rst_pins", {display_area, serial_output, hsync, vsync}, 4'b0011);
    check("rst_tenh", tenH_clk, 1'b0);
    check("rst_addr", glyph_addr, 0);
    reset = 1'b0;

    // Frame 0 with the 0xA5-at-0 bitmap; swap bitmap during vertical blanking.
    stats_on = 1'b1;
    repeat (HT * (VV + 1)) step();
    mem_mode = 1;
    repeat (HT * (VT - VV - 1)) step();
    stats_on = 1'b0;
    check("hs_low_cnt", hs_low, 96);
    check("hs_fall", hs_fall, 656 + 3);
    check("da_cnt", da_high, 640);
    check("vs_low_cnt", vs_low, VS * HT);
    check("vs_fall", vs_fall, (VV + VF) * HT + 3);
    check("first_byte", first_byte, 8'hA5);

    // Frame 1 with addr-as-data bitmap, then into frame 2 up to h=300, v=10.
    repeat (HT * VT) step();
    repeat (HT * 10 + 300) step();
    check("pre_rst_da", display_area, 1'b1);

    #1 reset = 1'b1;
    #1;
    check("mid_rst_pins", {display_area, serial_output, hsync, vsync}, 4'b0011);
    check("mid_rst_tenh", tenH_clk, 1'b0);
    check("mid_rst_addr", glyph_addr, 0);
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    check("mid_rst_hold", {display_area, serial_output, hsync, vsync}, 4'b0011);
    reset = 1'b0;
    sbq.delete();
    th = 0;
    tv = 0;
    edge_n = 0;
    exp_addr = 0;
    repeat (HT + 50) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
